sync_fifo_ovr: RTL and testbench
================================

# sync_fifo_ovr

Parametrised single-clock FIFO that generalises our fixed two-entry write-only buffer to N entries. It adds a read port, occupancy count, an almost-full threshold, sticky overflow and underflow error flags, and a build-time choice on full writes: drop the write or overwrite the oldest entry. It sits between producer and consumer blocks in the same clock domain. The output uses first-word fall-through: the oldest entry is always visible on `dout`.

## Interface
- `DATA_WIDTH`, 8: word width in bits.
- `DEPTH`, 4: number of entries. Must be a power of two, ≥2.
- `AF_LEVEL`, DEPTH-1: `almost_full` asserts when count ≥ AF_LEVEL. Legal range 1..DEPTH.
- `OVERWRITE`, 0: 0 drops writes when full; 1 overwrites the oldest entry when full.
- `clk` in 1: clock. All logic is on the rising edge.
- `resetn` in 1: reset, synchronous, active-low.
- `din` in DATA_WIDTH: write data.
- `wr` in 1: write request, sampled each cycle.
- `rd` in 1: read request; pops the entry currently on `dout`.
- `clr_err` in 1: synchronous clear of `overflow` and `underflow`.
- `dout` out DATA_WIDTH: oldest stored entry (combinational from storage).
- `count` out $clog2(DEPTH)+1: current occupancy, 0..DEPTH.
- `full` out 1: count == DEPTH.
- `empty` out 1: count == 0.
- `almost_full` out 1: count ≥ AF_LEVEL.
- `overflow` out 1: sticky; a write arrived while full with no same-cycle read.
- `underflow` out 1: sticky; a read arrived while empty.

## Operation
- **Storage:** DEPTH×DATA_WIDTH array.
  - Read and write pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
  - `count` is a separate register.
- **Reset** (resetn=0 at a clock edge):
  - Storage, pointers, count and both error flags clear to 0.
  - Resulting outputs: `dout`=0, `count`=0, `empty`=1, `full`=0, `almost_full`=0 (since AF_LEVEL ≥ 1), `overflow`=0, `underflow`=0.
  - Reset takes priority over all inputs, including mid-stream. No partial state is retained.
- **Write accepted:** `mem[wr_ptr]` <= `din`, and `wr_ptr` increments.
- **Read accepted:** `rd_ptr` increments. The popped data was already on `dout` during the cycle `rd` was high.
- **Cases per cycle** (n = count):
  - No `wr`, no `rd`: no change.
  - `wr` only, n<DEPTH: write accepted, n+1.
  - `wr` only, n==DEPTH, OVERWRITE=0: write dropped, storage unchanged, `overflow` set.
  - `wr` only, n==DEPTH, OVERWRITE=1: `mem[wr_ptr]` written and both pointers increment. Count stays DEPTH, the oldest entry is lost, and `overflow` is set.
  - `rd` only, n>0: read accepted, n-1.
  - `rd` only, n==0: ignored, `underflow` set.
  - `wr` and `rd`, 0<n: both accepted and count unchanged. This includes n==DEPTH, which sets no overflow in either mode.
  - `wr` and `rd`, n==0: write accepted and read ignored (no bypass). Count becomes 1 and `underflow` is set.
- **Error flags:**
  - Once set, they hold until `clr_err` or reset.
  - If `clr_err` and a new error occur in the same cycle, the flag is set (the error wins).
- `dout` while empty shows `mem[rd_ptr]`, which is stale data. Consumers must qualify `dout` with `!empty`.

## Timing
- Write-to-visible latency is 1 cycle. A write to an empty FIFO at edge k gives `dout`=`din`, `empty`=0 after edge k.
- Flags and count are registered-state derived. They update on the same edge as the pointers, with no extra cycle.
- Read is zero-latency for data: `dout` is valid in the cycle `rd` is asserted, and advances after the edge.
- Maximum throughput is one write and one read per cycle, with continuous streaming at any occupancy.
- `full`, `empty` and `almost_full` are pure functions of `count`. They never glitch relative to `count` at a clock edge.

## Test plan
Default parameters: DATA_WIDTH=8, DEPTH=4, AF_LEVEL=3.
1. **Reset then fill:** reset, then write 0x11, 0x22, 0x33, 0x44 on consecutive cycles.
   - `count` goes 1,2,3,4.
   - `almost_full` rises after the 3rd write; `full`=1 after the 4th.
   - `dout`=0x11 throughout.
2. **Drop on full, OVERWRITE=0:** from the full state of scenario 1, write 0x55.
   - Count stays 4 and `overflow`=1.
   - Four reads return 0x11, 0x22, 0x33, 0x44, then `empty`=1.
3. **Overwrite on full, OVERWRITE=1:** same stimulus as scenario 2.
   - Count stays 4 and `overflow`=1.
   - Reads return 0x22, 0x33, 0x44, 0x55.
4. **Simultaneous read and write:**
   - Full with 0x11..0x44, `wr`=`rd`=1 with `din`=0x66: count stays 4, no overflow, `dout` becomes 0x22.
   - Empty, `wr`=`rd`=1 with `din`=0x77: count becomes 1, `underflow`=1, `dout`=0x77.
5. **Wrap and stream:** 12 cycles of `wr`=`rd`=1 at count 2, with `din` incrementing from 0x01.
   - Output order is strictly FIFO across pointer wrap, and count stays 2.
6. **Error clear and mid-op reset:**
   - Pulse `clr_err`: both flags go to 0.
   - Apply `clr_err` together with a read while empty: `underflow` stays 1.
   - Assert `resetn`=0 at count 3: next cycle all outputs match reset values.

Source files
------------

// File: rtl/sync_fifo_ovr_if.sv
// Producer/consumer bundle for sync_fifo_ovr. The master side drives the
// write/read requests, and the slave side (the FIFO) returns data and status.
interface sync_fifo_ovr_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [DATA_WIDTH-1:0] din;
  logic                  wr;
  logic                  rd;
  logic                  clr_err;
  logic [DATA_WIDTH-1:0] dout;
  logic [CNT_W-1:0]      count;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output din, wr, rd, clr_err,
    input  dout, count, full, empty, almost_full, overflow, underflow
  );

  modport slave (
    input  din, wr, rd, clr_err,
    output dout, count, full, empty, almost_full, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_ovr.sv
// Single-clock first-word-fall-through FIFO with occupancy count, almost-full
// threshold, sticky overflow/underflow flags and optional overwrite-oldest on full.
module sync_fifo_ovr #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  parameter int AF_LEVEL   = DEPTH - 1,
  parameter bit OVERWRITE  = 1'b0
) (
  input  logic           clk,
  input  logic           resetn,
  sync_fifo_ovr_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_LEVEL);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_r;
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [CNT_W-1:0]      count_r;
  logic                  full_r;
  logic                  empty_r;
  logic                  af_r;
  logic                  ovf_r;
  logic                  unf_r;

  logic                  wr_fire_s;
  logic                  rd_fire_s;
  logic                  ovf_ev_s;
  logic                  unf_ev_s;
  logic [CNT_W-1:0]      count_nxt_s;

  // Decide which side of the FIFO moves this cycle and the resulting occupancy.
  always_comb begin
    wr_fire_s   = 1'b0;
    rd_fire_s   = 1'b0;
    ovf_ev_s    = 1'b0;
    unf_ev_s    = 1'b0;
    count_nxt_s = count_r;
    case ({bus.wr, bus.rd})
      2'b10: begin
        if (!full_r) begin
          wr_fire_s   = 1'b1;
          count_nxt_s = count_r + 1'b1;
        end else begin
          ovf_ev_s = 1'b1;
          // Overwrite mode advances both pointers so the oldest entry drops out.
          if (OVERWRITE) begin
            wr_fire_s = 1'b1;
            rd_fire_s = 1'b1;
          end else begin
            wr_fire_s = 1'b0;
          end
        end
      end
      2'b01: begin
        if (!empty_r) begin
          rd_fire_s   = 1'b1;
          count_nxt_s = count_r - 1'b1;
        end else begin
          unf_ev_s = 1'b1;
        end
      end
      2'b11: begin
        if (!empty_r) begin
          wr_fire_s = 1'b1;
          rd_fire_s = 1'b1;
        end else begin
          wr_fire_s   = 1'b1;
          unf_ev_s    = 1'b1;
          count_nxt_s = count_r + 1'b1;
        end
      end
      default: begin
        count_nxt_s = count_r;
      end
    endcase
  end

  // Storage, pointers, count and status flags; flags are registered from next count.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
      af_r     <= 1'b0;
      ovf_r    <= 1'b0;
      unf_r    <= 1'b0;
    end else begin
      if (wr_fire_s) begin
        mem_r[wr_ptr_r] <= bus.din;
        wr_ptr_r        <= wr_ptr_r + 1'b1;
      end
      if (rd_fire_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
      count_r <= count_nxt_s;
      full_r  <= (count_nxt_s == DEPTH_C);
      empty_r <= (count_nxt_s == {CNT_W{1'b0}});
      af_r    <= (count_nxt_s >= AF_C);
      // A new error in the same cycle as clr_err keeps the flag set.
      ovf_r   <= ovf_ev_s | (ovf_r & ~bus.clr_err);
      unf_r   <= unf_ev_s | (unf_r & ~bus.clr_err);
    end
  end

  assign bus.dout        = mem_r[rd_ptr_r];
  assign bus.count       = count_r;
  assign bus.full        = full_r;
  assign bus.empty       = empty_r;
  assign bus.almost_full = af_r;
  assign bus.overflow    = ovf_r;
  assign bus.underflow   = unf_r;
endmodule

// File: tb/tb_sync_fifo_ovr.sv
// Drives one stimulus stream into a drop-mode and an overwrite-mode FIFO and
// scoreboards each against a queue-based reference model.
module tb_sync_fifo_ovr;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int AF    = 3;

  logic          clk = 1'b0;
  logic          resetn;
  logic [DW-1:0] din;
  logic          wr;
  logic          rd;
  logic          clr_err;

  logic [DW-1:0] dout_a  [2];
  logic [31:0]   count_a [2];
  logic          ovf_a   [2];
  logic          unf_a   [2];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  task automatic check(input string name, input int inst, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL ovr%0d %s: got %0h expected %0h at %0t", inst, name, got, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : u
    sync_fifo_ovr_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

    sync_fifo_ovr #(
      .DATA_WIDTH(DW),
      .DEPTH     (DEPTH),
      .AF_LEVEL  (AF),
      .OVERWRITE (g == 1)
    ) dut (
      .clk   (clk),
      .resetn(resetn),
      .bus   (bus.slave)
    );

    assign bus.din     = din;
    assign bus.wr      = wr;
    assign bus.rd      = rd;
    assign bus.clr_err = clr_err;
    assign dout_a[g]   = bus.dout;
    assign count_a[g]  = 32'(bus.count);
    assign ovf_a[g]    = bus.overflow;
    assign unf_a[g]    = bus.underflow;

    logic [DW-1:0] mdl [$];
    logic          m_ovf   = 1'b0;
    logic          m_unf   = 1'b0;
    logic          m_fresh = 1'b0;
    logic          started = 1'b0;

    // Reference model: queue contents plus sticky error bits, updated at each edge.
    always @(posedge clk) begin
      if (!resetn) begin
        mdl.delete();
        m_ovf   <= 1'b0;
        m_unf   <= 1'b0;
        m_fresh <= 1'b1;
        started <= 1'b1;
      end else begin
        m_ovf <= (wr && !rd && mdl.size() == DEPTH) || (m_ovf && !clr_err);
        m_unf <= (rd && mdl.size() == 0) || (m_unf && !clr_err);
        if (wr) m_fresh <= 1'b0;
        if (wr && rd) begin
          if (mdl.size() > 0) void'(mdl.pop_front());
          mdl.push_back(din);
        end else if (wr) begin
          if (mdl.size() < DEPTH) begin
            mdl.push_back(din);
          end else if (g == 1) begin
            void'(mdl.pop_front());
            mdl.push_back(din);
          end
        end else if (rd) begin
          if (mdl.size() > 0) void'(mdl.pop_front());
        end
      end
    end

    // Monitor: compare visible outputs mid-cycle against the model.
    always @(negedge clk) begin
      if (started) begin
        check("count", g, 32'(bus.count), 32'(mdl.size()));
        check("full", g, 32'(bus.full), 32'(mdl.size() == DEPTH));
        check("empty", g, 32'(bus.empty), 32'(mdl.size() == 0));
        check("almost_full", g, 32'(bus.almost_full), 32'(mdl.size() >= AF));
        check("overflow", g, 32'(bus.overflow), 32'(m_ovf));
        check("underflow", g, 32'(bus.underflow), 32'(m_unf));
        if (mdl.size() > 0) begin
          if (rd) check("rd_data", g, 32'(bus.dout), 32'(mdl[0]));
          else    check("dout", g, 32'(bus.dout), 32'(mdl[0]));
        end else if (m_fresh) begin
          check("dout_after_reset", g, 32'(bus.dout), 32'd0);
        end
      end
    end
  end

  task automatic cyc(input logic rn, input logic w, input logic r,
                     input logic [DW-1:0] d, input logic c);
    resetn  = rn;
    wr      = w;
    rd      = r;
    din     = d;
    clr_err = c;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    logic [DW-1:0] fill [4];
    fill[0] = 8'h11; fill[1] = 8'h22; fill[2] = 8'h33; fill[3] = 8'h44;
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 8'hAA, 1'b1);

    // Reset then fill, then a write while full
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b0, fill[i], 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 8'h55, 1'b0);
    check("tp_drop_head", 0, 32'(dout_a[0]), 32'h11);
    check("tp_ovr_head", 1, 32'(dout_a[1]), 32'h22);
    check("tp_drop_ovf", 0, 32'(ovf_a[0]), 32'd1);
    check("tp_ovr_count", 1, count_a[1], 32'd4);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
    idle();

    // Simultaneous read/write while full, then drain past empty
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b0, fill[i], 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 8'h66, 1'b0);
    check("tp_full_wr_rd_head", 0, 32'(dout_a[0]), 32'h22);
    check("tp_full_wr_rd_ovf", 1, 32'(ovf_a[1]), 32'd0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 8'h77, 1'b0);
    check("tp_empty_wr_rd_data", 0, 32'(dout_a[0]), 32'h77);
    check("tp_empty_wr_rd_unf", 1, 32'(unf_a[1]), 32'd1);

    // Error clear, then clear racing a new underflow
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    cyc(1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 8'h00, 1'b1);
    check("tp_clr_vs_unf", 0, 32'(unf_a[0]), 32'd1);
    idle();

    // Streaming across pointer wrap at count 2
    cyc(1'b1, 1'b1, 1'b0, 8'hE0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 8'hE1, 1'b0);
    for (int i = 1; i <= 12; i++) cyc(1'b1, 1'b1, 1'b1, 8'(i), 1'b0);
    check("tp_stream_count", 0, count_a[0], 32'd2);
    check("tp_stream_head", 1, 32'(dout_a[1]), 32'h0B);

    // Mid-operation reset at count 3
    for (int i = 0; i < 3; i++) idle();
    cyc(1'b1, 1'b1, 1'b0, 8'h99, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 8'h98, 1'b0);
    check("tp_reset_count", 0, count_a[0], 32'd0);
    check("tp_reset_dout", 1, 32'(dout_a[1]), 32'd0);

    // Randomized traffic with alternating fill/drain bias
    for (int i = 0; i < 2000; i++) begin
      int wp;
      wp = ((i / 100) % 2 == 0) ? 70 : 35;
      cyc(($urandom_range(0, 299) != 0),
          ($urandom_range(0, 99) < wp),
          ($urandom_range(0, 99) < 100 - wp),
          8'($urandom),
          ($urandom_range(0, 19) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
